// File: rtl/led_status_gen_pkg.sv
// Shared constants and types for the LED status generator: mode encodings,
// channel FSM states, tick divider ratios and the code-mode gap multiplier.
package led_status_gen_pkg;

  localparam logic [1:0] MODE_OFF   = 2'b00;
  localparam logic [1:0] MODE_ON    = 2'b01;
  localparam logic [1:0] MODE_BLINK = 2'b10;
  localparam logic [1:0] MODE_CODE  = 2'b11;

  localparam int DIV_NORMAL = 1000;
  localparam int DIV_SIM    = 10;
  localparam int GAP_MULT   = 4;
  localparam int DIV_W      = 10;
  localparam int TIMER_W    = 12;

  typedef enum logic [2:0] {
    ST_OFF   = 3'd0,
    ST_ON    = 3'd1,
    ST_BLINK = 3'd2,
    ST_C_ON  = 3'd3,
    ST_C_OFF = 3'd4,
    ST_C_GAP = 3'd5
  } led_state_e;

  function automatic int divRatio(input int sim);
    return (sim != 0) ? DIV_SIM : DIV_NORMAL;
  endfunction

endpackage

// File: rtl/led_status_gen_if.sv
// Bus bundle of the LED status generator (enables, modes, codes, LEDs, ticks).
// With LED_STATUS_PWM_EN defined the bundle also carries the 4-bit dim level.
interface led_status_gen_if #(parameter int G_CH_COUNT = 4);

  logic                    p_in_clken;
  logic [2*G_CH_COUNT-1:0] p_in_mode;
  logic [4*G_CH_COUNT-1:0] p_in_code;
`ifdef LED_STATUS_PWM_EN
  logic [3:0]              p_in_dim;
`endif
  logic [G_CH_COUNT-1:0]   p_out_led;
  logic                    p_out_1us;
  logic                    p_out_1ms;
  logic                    p_out_1s;

`ifdef LED_STATUS_PWM_EN
  modport master (output p_in_clken, p_in_mode, p_in_code, p_in_dim,
                  input  p_out_led, p_out_1us, p_out_1ms, p_out_1s);
  modport slave  (input  p_in_clken, p_in_mode, p_in_code, p_in_dim,
                  output p_out_led, p_out_1us, p_out_1ms, p_out_1s);
`else
  modport master (output p_in_clken, p_in_mode, p_in_code,
                  input  p_out_led, p_out_1us, p_out_1ms, p_out_1s);
  modport slave  (input  p_in_clken, p_in_mode, p_in_code,
                  output p_out_led, p_out_1us, p_out_1ms, p_out_1s);
`endif

endinterface

// File: rtl/led_status_gen_tick.sv
// Tick chain for the LED status generator: us/ms/s pulse dividers plus the
// shared blink phase that every blinking channel follows.
module led_tick_gen
  import led_status_gen_pkg::*;
#(
  parameter int G_CLK_T05US = 62,
  parameter int G_BLINK_T05 = 125,
  parameter int G_SIM       = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic clken_i,
  output logic tickUs_o,
  output logic tickMs_o,
  output logic tickS_o,
  output logic blink_o
);

  localparam int US_W = $clog2(2*G_CLK_T05US + 1);
  localparam logic [US_W-1:0]  US_LAST    = US_W'(2*G_CLK_T05US - 1);
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(divRatio(G_SIM) - 1);
  localparam logic [DIV_W-1:0] BLINK_LAST = DIV_W'(G_BLINK_T05 - 1);

  logic [US_W-1:0]  usCnt_q, usCnt_d;
  logic [DIV_W-1:0] msCnt_q, msCnt_d, sCnt_q, sCnt_d, blinkCnt_q, blinkCnt_d;
  logic             tickUs_q, tickMs_q, tickS_q, blink_q, blink_d;
  logic             usWrap, msWrap, sWrap, blinkWrap;

  // All wraps derive from the same us wrap, so higher ticks coincide with it.
  always_comb begin
    usWrap     = clken_i && (usCnt_q == US_LAST);
    msWrap     = usWrap && (msCnt_q == DIV_LAST);
    sWrap      = msWrap && (sCnt_q == DIV_LAST);
    blinkWrap  = msWrap && (blinkCnt_q == BLINK_LAST);
    usCnt_d    = usCnt_q;
    msCnt_d    = msCnt_q;
    sCnt_d     = sCnt_q;
    blinkCnt_d = blinkCnt_q;
    blink_d    = blinkWrap ? ~blink_q : blink_q;
    if (clken_i) usCnt_d = usWrap ? '0 : usCnt_q + US_W'(1);
    if (usWrap) msCnt_d = msWrap ? '0 : msCnt_q + DIV_W'(1);
    if (msWrap) begin
      sCnt_d     = sWrap ? '0 : sCnt_q + DIV_W'(1);
      blinkCnt_d = blinkWrap ? '0 : blinkCnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      usCnt_q    <= '0;
      msCnt_q    <= '0;
      sCnt_q     <= '0;
      blinkCnt_q <= '0;
      blink_q    <= 1'b0;
      tickUs_q   <= 1'b0;
      tickMs_q   <= 1'b0;
      tickS_q    <= 1'b0;
    end else begin
      usCnt_q    <= usCnt_d;
      msCnt_q    <= msCnt_d;
      sCnt_q     <= sCnt_d;
      blinkCnt_q <= blinkCnt_d;
      blink_q    <= blink_d;
      tickUs_q   <= usWrap;
      tickMs_q   <= msWrap;
      tickS_q    <= sWrap;
    end
  end

  assign tickUs_o = tickUs_q;
  assign tickMs_o = tickMs_q;
  assign tickS_o  = tickS_q;
  assign blink_o  = blink_q;

endmodule

// File: rtl/led_status_gen.sv
// Multi-channel LED status generator: off/on/blink/flash-code per channel.
// Optional LED_STATUS_PWM_EN adds a 4-bit dimming PWM on every lit LED.
module led_status_gen
  import led_status_gen_pkg::*;
#(
  parameter int G_CH_COUNT  = 4,
  parameter int G_CLK_T05US = 62,
  parameter int G_BLINK_T05 = 125,
  parameter int G_SIM       = 0
) (
  input  logic             p_in_clk,
  input  logic             p_in_rst,
  led_status_gen_if.slave  bus
);

  localparam logic [TIMER_W-1:0] FLASH_LAST = TIMER_W'(G_BLINK_T05 - 1);
  localparam logic [TIMER_W-1:0] GAP_LAST   = TIMER_W'(GAP_MULT*G_BLINK_T05 - 1);

  logic                  tickUs, tickMs, tickS, blinkPhase, pwmGate;
  logic [G_CH_COUNT-1:0] ledVec;

  led_tick_gen #(
    .G_CLK_T05US (G_CLK_T05US),
    .G_BLINK_T05 (G_BLINK_T05),
    .G_SIM       (G_SIM)
  ) u_tick (
    .clk      (p_in_clk),
    .rst      (p_in_rst),
    .clken_i  (bus.p_in_clken),
    .tickUs_o (tickUs),
    .tickMs_o (tickMs),
    .tickS_o  (tickS),
    .blink_o  (blinkPhase)
  );

`ifdef LED_STATUS_PWM_EN
  logic [3:0] pwmCnt_q;

  always_ff @(posedge p_in_clk) begin
    if (p_in_rst) pwmCnt_q <= '0;
    else          pwmCnt_q <= pwmCnt_q + 4'd1;
  end

  assign pwmGate = (pwmCnt_q < bus.p_in_dim);
`else
  assign pwmGate = 1'b1;
`endif

  for (genvar i = 0; i < G_CH_COUNT; i++) begin : g_ch
    led_state_e         state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [3:0]         flash_q, flash_d;
    logic               led_q, lit, inCode, stepEnd;
    logic [1:0]         mode;
    logic [3:0]         code;

    assign mode = bus.p_in_mode[2*i +: 2];
    assign code = bus.p_in_code[4*i +: 4];

    always_ff @(posedge p_in_clk) begin
      if (p_in_rst) begin
        state_q <= ST_OFF;
        timer_q <= '0;
        flash_q <= '0;
        led_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        timer_q <= timer_d;
        flash_q <= flash_d;
        led_q   <= lit & pwmGate;
      end
    end

    // flash_q holds the flashes still owed in the current code sequence;
    // the last flash goes straight into the gap without a dark slot.
    always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      flash_d = flash_q;
      lit     = 1'b0;
      inCode  = state_q inside {ST_C_ON, ST_C_OFF, ST_C_GAP};
      stepEnd = tickMs && (timer_q == ((state_q == ST_C_GAP) ? GAP_LAST : FLASH_LAST));
      if (mode != MODE_CODE) begin
        timer_d = '0;
        flash_d = '0;
        case (mode)
          MODE_OFF:   state_d = ST_OFF;
          MODE_ON:    state_d = ST_ON;
          MODE_BLINK: state_d = ST_BLINK;
          default:    state_d = ST_OFF;
        endcase
      end else if (!inCode) begin
        timer_d = '0;
        flash_d = code;
        state_d = (code == 4'd0) ? ST_C_GAP : ST_C_ON;
      end else if (stepEnd) begin
        timer_d = '0;
        case (state_q)
          ST_C_ON: begin
            if (flash_q > 4'd1) begin
              flash_d = flash_q - 4'd1;
              state_d = ST_C_OFF;
            end else begin
              state_d = ST_C_GAP;
            end
          end
          ST_C_OFF: state_d = ST_C_ON;
          default: begin
            flash_d = code;
            state_d = (code == 4'd0) ? ST_C_GAP : ST_C_ON;
          end
        endcase
      end else if (tickMs) begin
        timer_d = timer_q + TIMER_W'(1);
      end
      case (state_d)
        ST_ON, ST_C_ON: lit = 1'b1;
        ST_BLINK:       lit = blinkPhase;
        default:        lit = 1'b0;
      endcase
    end

    assign ledVec[i] = led_q;
  end

  assign bus.p_out_led = ledVec;
  assign bus.p_out_1us = tickUs;
  assign bus.p_out_1ms = tickMs;
  assign bus.p_out_1s  = tickS;

endmodule

// File: tb/tb_led_status_gen.sv
// Directed bench for led_status_gen: one instance with 2 ms blink half-period
// for ticks/blink/clken checks, one with 1 ms for flash-code sequences.
module tb_led_status_gen;

  logic clk;
  logic rst;
  int   nChecks = 0;
  int   nFail   = 0;

  logic        rstV, ceV;
  logic [7:0]  modeB, modeC;
  logic [15:0] codeB, codeC;
`ifdef LED_STATUS_PWM_EN
  logic [3:0]  dimV;
`endif

  led_status_gen_if #(.G_CH_COUNT(4)) ifBlink ();
  led_status_gen_if #(.G_CH_COUNT(4)) ifCode ();

  led_status_gen #(
    .G_CH_COUNT(4), .G_CLK_T05US(2), .G_BLINK_T05(2), .G_SIM(1)
  ) u_dutBlink (
    .p_in_clk (clk),
    .p_in_rst (rst),
    .bus      (ifBlink)
  );

  led_status_gen #(
    .G_CH_COUNT(4), .G_CLK_T05US(2), .G_BLINK_T05(1), .G_SIM(1)
  ) u_dutCode (
    .p_in_clk (clk),
    .p_in_rst (rst),
    .bus      (ifCode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: summary not reached in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus();
    rst                = rstV;
    ifBlink.p_in_clken = ceV;
    ifBlink.p_in_mode  = modeB;
    ifBlink.p_in_code  = codeB;
    ifCode.p_in_clken  = ceV;
    ifCode.p_in_mode   = modeC;
    ifCode.p_in_code   = codeC;
`ifdef LED_STATUS_PWM_EN
    ifBlink.p_in_dim   = dimV;
    ifCode.p_in_dim    = dimV;
`endif
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nChecks++;
    assert (observed === expected) else begin
      nFail++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  function automatic logic tickSel(input int which);
    case (which)
      0:       return ifBlink.p_out_1us;
      1:       return ifBlink.p_out_1ms;
      default: return ifBlink.p_out_1s;
    endcase
  endfunction

  task automatic waitTick(input int which, input int limit, output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (tickSel(which) !== 1'b1 && cycles < limit);
  endtask

  task automatic waitBlinkChange(input int limit, output int cycles, inout int diffs);
    logic v;
    v = ifBlink.p_out_led[0];
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
      if (ifBlink.p_out_led[0] !== ifBlink.p_out_led[1]) diffs++;
    end while (ifBlink.p_out_led[0] === v && cycles < limit);
  endtask

  // Length of the run the code channel is currently in, counted from the
  // current sample; returns positioned on the first sample of the next run.
  task automatic nextRun(input int ch, output logic val, output int len);
    val = ifCode.p_out_led[ch];
    len = 0;
    while (ifCode.p_out_led[ch] === val && len < 1000) begin
      @(negedge clk);
      len++;
    end
  endtask

  task automatic expectRun(input string tag, input logic expVal, input int expLen);
    logic v;
    int   l;
    nextRun(0, v, l);
    checkOutput({tag, " level"}, {31'd0, v}, {31'd0, expVal});
    checkOutput({tag, " length"}, l, expLen);
  endtask

  initial begin
    int   cyc, diffs, ticks, changes, litCnt, found;
    logic hold, v;
    int   l;

    rstV = 1'b1; ceV = 1'b1;
    modeB = '0; codeB = '0; modeC = '0; codeC = '0;
`ifdef LED_STATUS_PWM_EN
    dimV = 4'd15;
`endif
    applyStimulus();
    repeat (3) @(negedge clk);
    checkOutput("reset led", ifBlink.p_out_led, 0);
    checkOutput("reset 1us", ifBlink.p_out_1us, 0);
    checkOutput("reset 1ms", ifBlink.p_out_1ms, 0);
    checkOutput("reset 1s", ifBlink.p_out_1s, 0);
    checkOutput("reset code led", ifCode.p_out_led, 0);

    // Tick chain: 4 clocks per us, 40 per ms, 400 per s
    rstV = 1'b0;
    applyStimulus();
    waitTick(0, 20, cyc);
    checkOutput("first 1us after reset", cyc, 4);
    waitTick(0, 20, cyc);
    checkOutput("1us period", cyc, 4);
    waitTick(1, 100, cyc);
    waitTick(1, 100, cyc);
    checkOutput("1ms period", cyc, 40);
    checkOutput("1ms aligned with 1us", ifBlink.p_out_1us, 1);
    waitTick(2, 1000, cyc);
    waitTick(2, 1000, cyc);
    checkOutput("1s period", cyc, 400);
    checkOutput("1s aligned with 1ms", ifBlink.p_out_1ms, 1);

    // Blink on channels 0 and 1: toggles every 2 ms = 80 clocks, in step
    modeB = 8'b0000_1010;
    applyStimulus();
    diffs = 0;
    waitBlinkChange(200, cyc, diffs);
    waitBlinkChange(200, cyc, diffs);
    waitBlinkChange(200, cyc, diffs);
    checkOutput("blink half period a", cyc, 80);
    waitBlinkChange(200, cyc, diffs);
    checkOutput("blink half period b", cyc, 80);
    checkOutput("blink channels in step", diffs, 0);

    modeB[5:4] = 2'b01;
    applyStimulus();
    @(negedge clk);
    checkOutput("mode01 one clock latency", ifBlink.p_out_led[2], 1);
    modeB[5:4] = 2'b00;
    applyStimulus();
    @(negedge clk);
    checkOutput("mode00 one clock latency", ifBlink.p_out_led[2], 0);

    // clken low: ticks stop and blink freezes, static modes still respond
    ceV = 1'b0;
    applyStimulus();
    @(negedge clk);
    hold = ifBlink.p_out_led[0];
    ticks = 0;
    changes = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ifBlink.p_out_1us === 1'b1 || ifBlink.p_out_1ms === 1'b1) ticks++;
      if (ifBlink.p_out_led[0] !== hold) changes++;
      if (i == 100) begin
        modeB[5:4] = 2'b01;
        applyStimulus();
      end
      if (i == 101) checkOutput("mode01 with clken low", ifBlink.p_out_led[2], 1);
    end
    checkOutput("ticks while clken low", ticks, 0);
    checkOutput("blink frozen while clken low", changes, 0);
    ceV = 1'b1;
    modeB[5:4] = 2'b00;
    applyStimulus();

    // Code 3 with 1 ms half period: 40 lit / 40 dark, last flash then 160 dark
    modeC[1:0] = 2'b11;
    codeC[3:0] = 4'd3;
    applyStimulus();
    found = 0;
    for (int k = 0; k < 12 && found == 0; k++) begin
      nextRun(0, v, l);
      if (v === 1'b0 && l == 160) found = 1;
    end
    checkOutput("code3 gap found", found, 1);
    for (int k = 0; k < 6; k++)
      expectRun("code3 sequence", (k % 2) == 0, (k == 5) ? 160 : 40);

    // Code changed to 1 during the first flash: this sequence still has 3
    codeC[3:0] = 4'd1;
    applyStimulus();
    for (int k = 0; k < 6; k++)
      expectRun("code change keeps 3", (k % 2) == 0, (k == 5) ? 160 : 40);
    expectRun("code1 flash a", 1'b1, 40);
    expectRun("code1 gap a", 1'b0, 160);
    expectRun("code1 flash b", 1'b1, 40);
    expectRun("code1 gap b", 1'b0, 160);

    // Reset in the middle of a flash
    repeat (5) @(negedge clk);
    checkOutput("lit before reset", ifCode.p_out_led[0], 1);
    rstV = 1'b1;
    applyStimulus();
    @(negedge clk);
    checkOutput("reset mid-flash led", ifCode.p_out_led[0], 0);
    checkOutput("reset mid-flash 1us", ifCode.p_out_1us, 0);
    rstV = 1'b0;
    modeC[1:0] = 2'b01;
    applyStimulus();
    @(negedge clk);
    checkOutput("mode01 after reset", ifCode.p_out_led[0], 1);
    // one of the four enabled clocks has already elapsed
    waitTick(0, 20, cyc);
    checkOutput("1us after reset release", cyc, 3);

    // Code 0 keeps the channel dark until a non-zero code is picked up at gap end
    modeC[3:2] = 2'b11;
    codeC[7:4] = 4'd0;
    applyStimulus();
    litCnt = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (ifCode.p_out_led[1] !== 1'b0) litCnt++;
    end
    checkOutput("code0 stays dark", litCnt, 0);
    codeC[7:4] = 4'd1;
    applyStimulus();
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (ifCode.p_out_led[1] !== 1'b1 && cyc < 250);
    checkOutput("code resampled at gap end", ifCode.p_out_led[1], 1);

`ifdef LED_STATUS_PWM_EN
    modeB[7:6] = 2'b01;
    dimV = 4'd4;
    applyStimulus();
    repeat (20) @(negedge clk);
    litCnt = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (ifBlink.p_out_led[3] === 1'b1) litCnt++;
    end
    checkOutput("pwm dim 4", litCnt, 4);
    dimV = 4'd0;
    applyStimulus();
    repeat (4) @(negedge clk);
    litCnt = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (ifBlink.p_out_led[3] !== 1'b0) litCnt++;
    end
    checkOutput("pwm dim 0", litCnt, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/led_status_gen.md
LED_STATUS_GEN -- requirements
Module: led_status_gen

Interface
REQ-001 SHALL have parameter G_CH_COUNT, default 4, number of LED channels (1..8).
REQ-002 SHALL have parameter G_CLK_T05US, default 62, clocks per half microsecond (1 us = 2*G_CLK_T05US clocks).
REQ-003 SHALL have parameter G_BLINK_T05, default 125, blink half-period in ms ticks (1..1023).
REQ-004 SHALL have parameter G_SIM, default 0; when 1, ms and s dividers are 10 instead of 1000.
REQ-005 SHALL have port p_in_clk, input, 1, the only clock; all logic on its rising edge.
REQ-006 SHALL have port p_in_rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port p_in_clken, input, 1, global count enable for the tick chain.
REQ-008 SHALL have port p_in_mode, input, 2*G_CH_COUNT, per-channel mode: 00 off, 01 on, 10 blink, 11 code.
REQ-009 SHALL have port p_in_code, input, 4*G_CH_COUNT, per-channel flash count for code mode.
REQ-010 SHALL have port p_out_led, output, G_CH_COUNT, registered LED drive, 1 = lit.
REQ-011 SHALL have ports p_out_1us, p_out_1ms and p_out_1s, output, 1 each, one-cycle tick pulses.

Function
REQ-012 The us counter SHALL advance only when p_in_clken=1 and pulse p_out_1us for one cycle on each wrap at 2*G_CLK_T05US-1.
REQ-013 The ms and s counters SHALL count 1us and 1ms ticks respectively (divide by 1000, or 10 if G_SIM) and pulse on wrap, in the same cycle as the enabling lower tick.
REQ-014 A shared blink phase SHALL toggle every G_BLINK_T05 ms ticks; mode 10 drives the LED with this phase, so all blinking channels stay in step.
REQ-015 Each channel SHALL contain an FSM with states OFF, ON, BLINK, C_ON, C_OFF and C_GAP; each state is selected from p_in_mode at every clock except inside a code sequence.
REQ-016 Code mode SHALL latch p_in_code on entry to C_ON, emit that many flashes (lit G_BLINK_T05 ms, dark G_BLINK_T05 ms), then stay dark in C_GAP for 4*G_BLINK_T05 ms, then repeat.
REQ-017 A latched code of 0 SHALL hold the channel dark, re-sampling p_in_code at each gap end.
REQ-018 A mode change away from 11 SHALL abort the code sequence and take effect at the next clock; changes of p_in_code mid-sequence SHALL take effect only at the next sequence start.
REQ-019 Latency from a p_in_mode change to p_out_led SHALL be exactly one clock for modes 00 and 01.
REQ-020 With p_in_clken=0, ticks SHALL stop and blink or code outputs SHALL freeze; modes 00 and 01 still respond.

Reset
REQ-021 While p_in_rst=1, all counters, the blink phase and every FSM SHALL go to zero or OFF, and p_out_led plus all tick outputs SHALL be 0 in the following cycle.
REQ-022 Reset asserted mid-sequence SHALL discard the latched code; after release, the first 1us tick SHALL occur 2*G_CLK_T05US enabled clocks later.

Configuration
REQ-023 When macro LED_STATUS_PWM_EN is defined, the block SHALL have input p_in_dim, 4 bits.
REQ-024 With LED_STATUS_PWM_EN, every lit LED SHALL be gated by a free-running 4-bit PWM: lit while pwm_cnt < p_in_dim, and 15 means fully lit except one slot in 16.
REQ-025 Without LED_STATUS_PWM_EN, p_in_dim SHALL not exist and lit means constantly 1.

Structure
REQ-026 A shared package SHALL hold the mode encoding constants, the FSM state typedef, the divider constants (1000, 10) and the gap multiplier (4).
REQ-027 Tick generation SHALL be a sub-module named led_tick_gen; the per-channel FSM SHALL be a generate loop in led_status_gen.

Verification
REQ-028 Bench: G_CLK_T05US=2, G_SIM=1 and clken=1 -> p_out_1us every 4 clocks, p_out_1ms every 40 clocks, p_out_1s every 400 clocks.
REQ-029 Bench: G_BLINK_T05=2 and channel 0 in mode 10 -> LED toggles every 80 clocks; two blinking channels stay identical.
REQ-030 Bench: mode 11 with code 3 and G_BLINK_T05=1 -> three 40-clock lit pulses separated by 40 clocks dark, then 160 clocks dark, then repeat.
REQ-031 Bench: code changed 3 to 1 mid-sequence -> current sequence completes 3 flashes and the next sequence has 1 flash.
REQ-032 Bench: reset pulsed mid-flash -> LED 0 next cycle; mode 01 after release -> LED 1 one clock later.
REQ-033 Bench: with LED_STATUS_PWM_EN, p_in_dim=4 and mode 01 -> LED high 4 of every 16 clocks; p_in_dim=0 -> LED stays 0.
